// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Round-robin, burst-bounded arbiter sharing one synchronous
//               instruction ROM between CPU fetch (port 0) and a debug/loader
//               master (port 1).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_in,
    input  logic [ADDR_W-1:0] m0_addr_in,
    output logic              m0_gnt_out,
    output logic              m0_rvalid_out,
    input  logic              m1_req_in,
    input  logic [ADDR_W-1:0] m1_addr_in,
    output logic              m1_gnt_out,
    output logic              m1_rvalid_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rom_en_out,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in
);

    localparam int                 c_BCNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_BCNT_W-1:0] c_BURST_LAST = c_BCNT_W'(MAX_BURST - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE   = c_BCNT_W'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t              r_owner;
    owner_t              w_owner_nxt;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic [c_BCNT_W-1:0] w_bcnt_nxt;
    logic                r_last;        // 0: port 0 granted last, 1: port 1
    logic                r_m0_rvalid;
    logic                r_m1_rvalid;
    logic                w_gnt0;
    logic                w_gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_NONE;
            r_bcnt      <= '0;
            r_last      <= 1'b1;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_m0_rvalid <= w_gnt0;
            r_m1_rvalid <= w_gnt1;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
        end
    end

    // The burst counter only advances under contention; any uncontended
    // grant or idle cycle restarts the burst window.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_owner_nxt = OWN_NONE;
        w_bcnt_nxt  = '0;
        if (m0_req_in && m1_req_in) begin
            case (r_owner)
                OWN_P0: begin
                    if (r_bcnt < c_BURST_LAST) begin
                        w_gnt0      = 1'b1;
                        w_owner_nxt = OWN_P0;
                        w_bcnt_nxt  = r_bcnt + c_BCNT_ONE;
                    end else begin
                        w_gnt1      = 1'b1;
                        w_owner_nxt = OWN_P1;
                    end
                end
                OWN_P1: begin
                    if (r_bcnt < c_BURST_LAST) begin
                        w_gnt1      = 1'b1;
                        w_owner_nxt = OWN_P1;
                        w_bcnt_nxt  = r_bcnt + c_BCNT_ONE;
                    end else begin
                        w_gnt0      = 1'b1;
                        w_owner_nxt = OWN_P0;
                    end
                end
                default: begin
                    if (r_last) begin
                        w_gnt0      = 1'b1;
                        w_owner_nxt = OWN_P0;
                    end else begin
                        w_gnt1      = 1'b1;
                        w_owner_nxt = OWN_P1;
                    end
                end
            endcase
        end else if (m0_req_in) begin
            w_gnt0      = 1'b1;
            w_owner_nxt = OWN_P0;
        end else if (m1_req_in) begin
            w_gnt1      = 1'b1;
            w_owner_nxt = OWN_P1;
        end
    end

    // Outputs are forced quiet for the whole time reset is high, not just at edges.
    assign m0_gnt_out    = w_gnt0 & ~rst;
    assign m1_gnt_out    = w_gnt1 & ~rst;
    assign rom_en_out    = m0_gnt_out | m1_gnt_out;
    assign rom_addr_out  = m0_gnt_out ? m0_addr_in :
                           m1_gnt_out ? m1_addr_in : '0;
    assign m0_rvalid_out = r_m0_rvalid;
    assign m1_rvalid_out = r_m1_rvalid;
    assign rdata_out     = rom_data_in;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_arbiter
// Description : Directed self-checking bench for inst_rom_arbiter with a
//               synchronous ROM model (word = 0xDEAD0000 | addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata, rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        rom_en;

    int tests  = 0;
    int failed = 0;
    int wait0  = 0;
    int wait1  = 0;

    inst_rom_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_in     (m0_req),
        .m0_addr_in    (m0_addr),
        .m0_gnt_out    (m0_gnt),
        .m0_rvalid_out (m0_rvalid),
        .m1_req_in     (m1_req),
        .m1_addr_in    (m1_addr),
        .m1_gnt_out    (m1_gnt),
        .m1_rvalid_out (m1_rvalid),
        .rdata_out     (rdata),
        .rom_en_out    (rom_en),
        .rom_addr_out  (rom_addr),
        .rom_data_in   (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hDEAD_0000 | rom_addr;
    end

    // Invariant monitor, sampled just before each rising edge.
    always @(negedge clk) begin
        #4;
        tests++;
        if (m0_gnt && m1_gnt) begin
            failed++; $display("FAIL mon_two_gnt got=%b%b exp=not 11", m0_gnt, m1_gnt);
        end
        tests++;
        if (rom_en !== (m0_gnt | m1_gnt)) begin
            failed++; $display("FAIL mon_rom_en got=%b exp=%b", rom_en, m0_gnt | m1_gnt);
        end
        tests++;
        if ((m0_gnt && !m0_req) || (m1_gnt && !m1_req)) begin
            failed++; $display("FAIL mon_gnt_without_req gnt=%b%b req=%b%b", m0_gnt, m1_gnt, m0_req, m1_req);
        end
        if (rst) begin
            wait0 = 0; wait1 = 0;
        end else begin
            wait0 = (m0_req && !m0_gnt) ? wait0 + 1 : 0;
            wait1 = (m1_req && !m1_gnt) ? wait1 + 1 : 0;
        end
        tests++;
        if (wait0 > MAX_BURST || wait1 > MAX_BURST) begin
            failed++; $display("FAIL mon_starvation got=%0d/%0d exp<=%0d", wait0, wait1, MAX_BURST);
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({m0_gnt, m1_gnt, rom_en, m0_rvalid, m1_rvalid} !== 5'b0) begin
            failed++; $display("FAIL reset_outputs got=%b exp=00000", {m0_gnt, m1_gnt, rom_en, m0_rvalid, m1_rvalid});
        end
        tests++;
        if (rom_addr !== 32'h0) begin
            failed++; $display("FAIL reset_rom_addr got=%h exp=00000000", rom_addr);
        end
        @(negedge clk);
        rst = 1'b0; m1_req = 1'b0; m0_addr = 32'h10;
        #1;
        tests++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || rom_addr !== 32'h10) begin
            failed++; $display("FAIL reset_first_gnt got=%b%b/%h exp=10/00000010", m0_gnt, m1_gnt, rom_addr);
        end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        tests++;
        if (m0_rvalid !== 1'b1 || rdata !== 32'hDEAD0010) begin
            failed++; $display("FAIL reset_first_rdata got=%b/%h exp=1/dead0010", m0_rvalid, rdata);
        end
        // Reset arriving mid-cycle must kill an in-flight grant immediately.
        m0_req = 1'b1; m0_addr = 32'h20;
        #1;
        tests++;
        if (m0_gnt !== 1'b1) begin
            failed++; $display("FAIL reset_pre_midcycle got=%b exp=1", m0_gnt);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (m0_gnt !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 32'h0) begin
            failed++; $display("FAIL reset_midcycle got=%b%b/%h exp=00/00000000", m0_gnt, rom_en, rom_addr);
        end
        @(negedge clk);
        rst = 1'b0; m0_req = 1'b0;
        #1;
        tests++;
        if (m0_rvalid !== 1'b0) begin
            failed++; $display("FAIL reset_no_rvalid got=%b exp=0", m0_rvalid);
        end
    endtask

    task automatic test_single_stream();
        logic [31:0] exp_data;
        @(negedge clk);
        m1_req = 1'b1; m1_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (m1_gnt !== (i < 3) || m0_gnt !== 1'b0) begin
                failed++; $display("FAIL stream_gnt[%0d] got=%b%b exp=0%b", i, m0_gnt, m1_gnt, i < 3);
            end
            if (i > 0) begin
                exp_data = 32'hDEAD0000 | (32'(i - 1) * 32'd4);
                tests++;
                if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || rdata !== exp_data) begin
                    failed++; $display("FAIL stream_rdata[%0d] got=%b/%h exp=1/%h", i, m1_rvalid, rdata, exp_data);
                end
            end
            @(negedge clk);
            m1_addr = 32'(i + 1) * 32'd4;
            if (i == 2) m1_req = 1'b0;
        end
        #1;
        tests++;
        if (m1_rvalid !== 1'b0) begin
            failed++; $display("FAIL stream_rvalid_end got=%b exp=0", m1_rvalid);
        end
    endtask

    task automatic test_contention();
        logic e0;
        logic prev0;
        prev0 = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 16; i++) begin
            e0 = ((i / 4) % 2) == 0;
            #1;
            tests++;
            if (m0_gnt !== e0 || m1_gnt !== !e0) begin
                failed++; $display("FAIL contention_gnt[%0d] got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, e0, !e0);
            end
            if (i > 0) begin
                tests++;
                if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin
                    failed++; $display("FAIL contention_rvalid[%0d] got=%b%b exp=%b%b", i, m0_rvalid, m1_rvalid, prev0, !prev0);
                end
            end
            prev0 = e0;
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_idle_tie();
        @(negedge clk);
        m0_req = 1'b1;
        #1;
        tests++;
        if (m0_gnt !== 1'b1) begin
            failed++; $display("FAIL tie_setup_gnt got=%b exp=1", m0_gnt);
        end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        tests++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            failed++; $display("FAIL tie_idle got=%b%b exp=00", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        tests++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
            failed++; $display("FAIL tie_winner got=%b%b exp=01", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_owner_drop();
        logic [7:0] m0_pat;
        logic [7:0] g1_pat;
        m0_pat = 8'b1111_0111;
        g1_pat = 8'b0111_1000;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            m0_req = m0_pat[i]; m1_req = 1'b1;
            #1;
            tests++;
            if (m1_gnt !== g1_pat[i] || m0_gnt !== (m0_pat[i] & !g1_pat[i])) begin
                failed++; $display("FAIL owner_drop_gnt[%0d] got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, m0_pat[i] & !g1_pat[i], g1_pat[i]);
            end
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_reset_outstanding();
        @(negedge clk);
        @(negedge clk);
        m1_req = 1'b1; m1_addr = 32'h30;
        #1;
        tests++;
        if (m1_gnt !== 1'b1) begin
            failed++; $display("FAIL rst_out_gnt got=%b exp=1", m1_gnt);
        end
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (m1_rvalid !== 1'b0 || m1_gnt !== 1'b0 || rom_en !== 1'b0) begin
            failed++; $display("FAIL rst_out_dropped got=%b%b%b exp=000", m1_rvalid, m1_gnt, rom_en);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (m1_rvalid !== 1'b0 || m1_gnt !== 1'b1 || rom_addr !== 32'h30) begin
            failed++; $display("FAIL rst_out_reissue got=%b%b/%h exp=01/00000030", m1_rvalid, m1_gnt, rom_addr);
        end
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        tests++;
        if (m1_rvalid !== 1'b1 || rdata !== 32'hDEAD0030) begin
            failed++; $display("FAIL rst_out_rdata got=%b/%h exp=1/dead0030", m1_rvalid, rdata);
        end
        @(negedge clk);
        #1;
        tests++;
        if (m1_rvalid !== 1'b0) begin
            failed++; $display("FAIL rst_out_rvalid_end got=%b exp=0", m1_rvalid);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_addr = 32'hAA; m1_addr = 32'hBB;
        test_reset();
        test_single_stream();
        test_contention();
        test_idle_tie();
        test_owner_drop();
        test_reset_outstanding();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
